// File: rtl/tlcd_pkg.sv
// Shared constants and types for the LCD message arbiter: blank text,
// FSM encoding, default timing and 5 kHz clock-time constants.
package tlcd_pkg;

    localparam logic [127:0] BLANK_LINE = {16{8'h20}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam int unsigned DEF_RST_PULSE   = 2;
    localparam int unsigned DEF_HOLD_CYCLES = 2500;

    localparam int unsigned CLK_HZ        = 5000;
    localparam int unsigned CLK_PERIOD_US = 1_000_000 / CLK_HZ;
    localparam int unsigned CYCLES_PER_MS = CLK_HZ / 1000;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker; LAST remembers the most recent winner
// so a tie goes to the other requester.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic       valid,
    output logic       winner
);

    logic last;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        valid  = |req;
        winner = req[1];
        if (req == 2'b11) winner = ~last;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                last <= 1'b1;
        else if (update && valid)  last <= winner;
    end

endmodule

// File: rtl/tlcd_msg_arbiter.sv
// Grants one of two text sources to the LCD controller, latches its text and
// forces a full redraw with a timed LCD_RESETN pulse followed by a hold-off.
module tlcd_msg_arbiter
    import tlcd_pkg::*;
#(
    parameter int unsigned RST_PULSE   = DEF_RST_PULSE,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic         CLK,
    input  logic         RESETN,
    input  logic [1:0]   REQ,
    input  logic [127:0] TEXT_UPPER_0,
    input  logic [127:0] TEXT_LOWER_0,
    input  logic [127:0] TEXT_UPPER_1,
    input  logic [127:0] TEXT_LOWER_1,
    output logic [1:0]   ACK,
    output logic         GRANT_ID,
    output logic [127:0] TEXT_STRING_UPPER,
    output logic [127:0] TEXT_STRING_LOWER,
    output logic         LCD_RESETN,
    output logic         BUSY
);

    localparam logic [15:0] PULSE_LOAD = 16'(RST_PULSE - 1);
    localparam logic [15:0] HOLD_LOAD  = 16'(HOLD_CYCLES - 1);

    state_t      state;
    logic [15:0] cnt;
    logic        grant_valid;
    logic        winner;

    rr_arb2 u_arb (
        .clk    (CLK),
        .rst_n  (RESETN),
        .req    (REQ),
        .update (state == ST_IDLE),
        .valid  (grant_valid),
        .winner (winner)
    );

    // Reset lands in PULSE so the display is blanked and redrawn after power-up.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state             <= ST_PULSE;
            cnt               <= PULSE_LOAD;
            TEXT_STRING_UPPER <= BLANK_LINE;
            TEXT_STRING_LOWER <= BLANK_LINE;
            ACK               <= 2'b00;
            GRANT_ID          <= 1'b0;
            LCD_RESETN        <= 1'b0;
            BUSY              <= 1'b1;
        end else begin
            ACK <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        TEXT_STRING_UPPER <= winner ? TEXT_UPPER_1 : TEXT_UPPER_0;
                        TEXT_STRING_LOWER <= winner ? TEXT_LOWER_1 : TEXT_LOWER_0;
                        GRANT_ID          <= winner;
                        ACK               <= winner ? 2'b10 : 2'b01;
                        LCD_RESETN        <= 1'b0;
                        BUSY              <= 1'b1;
                        cnt               <= PULSE_LOAD;
                        state             <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (cnt == 16'd0) begin
                        LCD_RESETN <= 1'b1;
                        cnt        <= HOLD_LOAD;
                        state      <= ST_HOLD;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == 16'd0) begin
                        BUSY  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A zero parameter would make the counter load wrap to 16'hFFFF.
    always_ff @(posedge CLK) begin
        assert (RST_PULSE >= 1 && RST_PULSE <= 15 &&
                HOLD_CYCLES >= 1 && HOLD_CYCLES <= 65535);
    end

endmodule

// File: tb/tb_tlcd_msg_arbiter.sv
// Randomized bench: a cycle-gap reference model predicts each grant into a
// scoreboard queue; a negedge monitor pops and compares on every ACK.
module tb_tlcd_msg_arbiter;

    localparam int RST_PULSE   = 2;
    localparam int HOLD_CYCLES = 10;
    localparam int GAP         = RST_PULSE + HOLD_CYCLES + 1;
    localparam logic [127:0] BLANK = {16{8'h20}};

    logic         CLK = 1'b0;
    logic         RESETN = 1'b0;
    logic [1:0]   REQ = 2'b00;
    logic [127:0] TEXT_UPPER_0 = '0, TEXT_LOWER_0 = '0;
    logic [127:0] TEXT_UPPER_1 = '0, TEXT_LOWER_1 = '0;
    logic [1:0]   ACK;
    logic         GRANT_ID;
    logic [127:0] TEXT_STRING_UPPER, TEXT_STRING_LOWER;
    logic         LCD_RESETN, BUSY;

    tlcd_msg_arbiter #(.RST_PULSE(RST_PULSE), .HOLD_CYCLES(HOLD_CYCLES)) dut (
        .CLK               (CLK),
        .RESETN            (RESETN),
        .REQ               (REQ),
        .TEXT_UPPER_0      (TEXT_UPPER_0),
        .TEXT_LOWER_0      (TEXT_LOWER_0),
        .TEXT_UPPER_1      (TEXT_UPPER_1),
        .TEXT_LOWER_1      (TEXT_LOWER_1),
        .ACK               (ACK),
        .GRANT_ID          (GRANT_ID),
        .TEXT_STRING_UPPER (TEXT_STRING_UPPER),
        .TEXT_STRING_LOWER (TEXT_STRING_LOWER),
        .LCD_RESETN        (LCD_RESETN),
        .BUSY              (BUSY)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] required);
        tests++;
        if (actual !== required) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, actual, required, $time);
        end
    endtask

    typedef struct {
        logic [1:0]   ack;
        logic         id;
        logic [127:0] up;
        logic [127:0] lo;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: cycles since the last grant (or reset release) decide
    // whether a request can be served; ties alternate away from the last winner.
    int           since  = 0;
    logic         m_last = 1'b1;
    logic         exp_id = 1'b0;
    logic [127:0] exp_up = BLANK, exp_lo = BLANK;

    always @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            since  = 0;
            m_last = 1'b1;
            exp_id = 1'b0;
            exp_up = BLANK;
            exp_lo = BLANK;
            sb_q.delete();
        end else begin
            if (since < GAP) since++;
            if (since >= GAP && REQ != 2'b00) begin
                exp_t e;
                logic w;
                w      = (REQ == 2'b11) ? !m_last : REQ[1];
                exp_id = w;
                exp_up = w ? TEXT_UPPER_1 : TEXT_UPPER_0;
                exp_lo = w ? TEXT_LOWER_1 : TEXT_LOWER_0;
                e.ack  = w ? 2'b10 : 2'b01;
                e.id   = w;
                e.up   = exp_up;
                e.lo   = exp_lo;
                sb_q.push_back(e);
                m_last = w;
                since  = 0;
            end
        end
    end

    // Monitor: grant transactions come from the queue, steady outputs from the model.
    always @(negedge CLK) begin
        if (ACK != 2'b00) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ack", ACK, 2'b00);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("ack", ACK, e.ack);
                check("ack_grant_id", GRANT_ID, e.id);
                check("ack_text_upper", TEXT_STRING_UPPER, e.up);
                check("ack_text_lower", TEXT_STRING_LOWER, e.lo);
            end
        end else if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("missing_ack", ACK, e.ack);
        end
        check("lcd_resetn", LCD_RESETN, since >= RST_PULSE);
        check("busy", BUSY, since < RST_PULSE + HOLD_CYCLES);
        check("grant_id", GRANT_ID, exp_id);
        check("text_upper", TEXT_STRING_UPPER, exp_up);
        check("text_lower", TEXT_STRING_LOWER, exp_lo);
    end

    function automatic logic [127:0] rand_text();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic pulse_reset(input int cycles);
        @(negedge CLK);
        #2 RESETN = 1'b0;
        repeat (cycles) @(negedge CLK);
        #2 RESETN = 1'b1;
    endtask

    task automatic wait_ack(input int idx, input int budget);
        int n = 0;
        while (ACK[idx] !== 1'b1 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (ACK[idx] !== 1'b1) check("ack_timeout", ACK, idx == 1 ? 2'b10 : 2'b01);
    endtask

    initial begin
        logic [127:0] hello;
        hello = "HELLO WORLD!    ";
        TEXT_UPPER_0 = rand_text();
        TEXT_LOWER_0 = rand_text();
        TEXT_UPPER_1 = rand_text();
        TEXT_LOWER_1 = rand_text();

        // Power-up blanking sequence with no requests.
        repeat (3) @(negedge CLK);
        #2 RESETN = 1'b1;
        repeat (20) @(negedge CLK);

        // Single request from requester 0 with known text, then text changes after ACK.
        TEXT_UPPER_0 = hello;
        REQ = 2'b01;
        wait_ack(0, 30);
        REQ = 2'b00;
        @(negedge CLK);
        TEXT_UPPER_0 = rand_text();
        TEXT_LOWER_0 = rand_text();
        repeat (15) @(negedge CLK);

        // Both held: grants alternate.
        REQ = 2'b11;
        repeat (70) @(negedge CLK);
        REQ = 2'b00;
        repeat (15) @(negedge CLK);

        // Requester 1 raises mid-HOLD and is served on the first IDLE cycle.
        REQ = 2'b01;
        wait_ack(0, 30);
        REQ = 2'b00;
        repeat (6) @(negedge CLK);
        REQ = 2'b10;
        wait_ack(1, 30);
        REQ = 2'b00;
        repeat (15) @(negedge CLK);

        // Reset during HOLD after a grant to requester 1.
        REQ = 2'b10;
        wait_ack(1, 30);
        REQ = 2'b00;
        repeat (5) @(negedge CLK);
        pulse_reset(3);
        repeat (20) @(negedge CLK);

        // Randomized traffic with text churn and rare resets.
        for (int i = 0; i < 2000; i++) begin
            @(negedge CLK);
            if ($urandom_range(0, 3) == 0) REQ = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) TEXT_UPPER_0 = rand_text();
            if ($urandom_range(0, 3) == 0) TEXT_LOWER_0 = rand_text();
            if ($urandom_range(0, 3) == 0) TEXT_UPPER_1 = rand_text();
            if ($urandom_range(0, 3) == 0) TEXT_LOWER_1 = rand_text();
            if ($urandom_range(0, 499) == 0) pulse_reset(2);
        end

        REQ = 2'b00;
        repeat (20) @(negedge CLK);
        check("scoreboard_empty", 128'(sb_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
